arbiter_requester: RTL and testbench
====================================

Name: arbiter_requester

Overview:
- Requester-side companion to the static priority arbiter used in the router crossbars.
- Queues local transfer commands and drives one `requests[i]` line into the arbiter.
- Consumes the matching `grants[i]` line and sequences a multi-beat ownership window for each command.
- Inserts a one-cycle release bubble after every burst and raises a sticky starvation alarm when a request waits too long.

Parameters:
- DEPTH_LOG2, 2, log2 of command queue depth (depth = 2**DEPTH_LOG2 = 4).
- LEN_WIDTH, 4, width of the burst-length field; burst = cmd_len+1 beats (1..16).
- STARVE_WIDTH, 8, width of the starvation wait counter.
- STARVE_LIMIT, 64, wait cycles in REQ without grant that trigger the alarm; must be < 2**STARVE_WIDTH.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- cmd_valid  in  1  command offered by local source.
- cmd_len  in  LEN_WIDTH  burst length minus one.
- cmd_ready  out  1  queue can accept a command.
- request  out  1  to arbiter `requests[i]`.
- grant  in  1  from arbiter `grants[i]` (combinational response to request).
- own  out  1  beat transfers this cycle.
- own_first  out  1  first beat of burst (qualified by own).
- own_last  out  1  last beat of burst (qualified by own).
- pending  out  DEPTH_LOG2+1  commands queued, including the one in flight.
- starved  out  1  sticky starvation alarm.
- starve_clear  in  1  clears starved.

Behaviour:
- Reset (async, active-high): request=0, own=0, own_first=0, own_last=0, pending=0, starved=0, cmd_ready=1. Queue emptied; FSM->IDLE; counters cleared. Reset mid-burst aborts the burst; there is no resumption.
- Queue: push when cmd_valid && cmd_ready.
  - cmd_ready = (pending < 2**DEPTH_LOG2), derived from registered count only. No push when full, even on a pop cycle.
  - Pop on the own_last beat.
  - Simultaneous push and pop leaves pending unchanged.
- FSM states IDLE, REQ, OWN, GAP:
  - IDLE: request=0. Go to REQ the cycle after pending becomes nonzero.
  - REQ: request=1. If grant=1 at the clock edge, go to OWN and load beat_rem = cmd_len of the head entry. Otherwise stay in REQ.
  - OWN: request=1 and own = grant.
    - grant=0 during OWN stalls the burst: beat_rem held, own=0, state stays OWN. This covers preemption by a lower-index requester.
    - Each own cycle decrements beat_rem. own_last = own && beat_rem==0, after which the FSM goes to GAP.
    - own_first = own on the first transferring beat of the burst. It is tracked by a flag, not by the OWN entry cycle.
  - GAP: request=0 for exactly 1 cycle so higher-index requesters can win. Then go to REQ if pending (after pop) is nonzero, else IDLE.
- Grant latency: the first beat can occur in the first OWN cycle, i.e. 1 cycle after grant is seen in REQ. Minimum command-to-first-beat latency is 3 cycles: push, IDLE->REQ, REQ->OWN.
- A grant seen while request=0 (IDLE/GAP) is ignored.
- Starvation:
  - wait_cnt increments each REQ cycle with grant=0, saturating at STARVE_LIMIT. It clears on entering OWN.
  - When wait_cnt reaches STARVE_LIMIT, starved is set.
  - starve_clear clears starved. If set and clear coincide, set wins.
  - wait_cnt does not count during OWN stalls.
- Burst of length 1 (cmd_len=0): own_first and own_last both asserted on the same beat.
- All outputs except cmd_ready and own/own_first/own_last are registered. own* are combinational from state and grant.

Test Plan:
- Single command cmd_len=3, grant tied to request -> request high from cycle 2; own high cycles 3..6; own_first at 3, own_last at 6; request=0 at cycle 7 (GAP); pending 1->0 at cycle 7; then IDLE.
- Push 5 back-to-back commands with grant=0 -> cmd_ready drops after 4th accept; pending=4; 5th held; no push while full even on a pop cycle.
- Two queued commands (cmd_len=1 each), grant always 1 -> beats 2, one GAP cycle with request=0, REQ, 2 more beats; own_last pulses twice; pending ends at 0.
- Grant dropped for 3 cycles mid-burst (cmd_len=4) -> own low for those 3 cycles, beat_rem held; total own cycles still 5; own_first only once.
- grant=0 for 64 REQ cycles -> starved rises at wait 64 and stays high; starve_clear pulse on a non-setting cycle clears it; clear coincident with the set cycle leaves starved=1.
- Assert reset during beat 2 of a 4-beat burst with pending=3 -> request, own and pending go to 0 immediately (async); after release cmd_ready=1 and the FSM is in IDLE.

Source files
------------

// File: rtl/arbiter_requester.sv
// Requester side of the crossbar priority arbiter: queues burst commands, requests the
// arbiter, sequences multi-beat ownership with a release bubble, and flags starvation.
module arbiter_requester #(
  parameter int DEPTH_LOG2   = 2,
  parameter int LEN_WIDTH    = 4,
  parameter int STARVE_WIDTH = 8,
  parameter int STARVE_LIMIT = 64
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cmd_valid,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  output logic                  cmd_ready,
  output logic                  request,
  input  logic                  grant,
  output logic                  own,
  output logic                  own_first,
  output logic                  own_last,
  output logic [DEPTH_LOG2:0]   pending,
  output logic                  starved,
  input  logic                  starve_clear
);
  localparam int DEPTH = 2**DEPTH_LOG2;
  localparam logic [STARVE_WIDTH-1:0] LIMIT    = STARVE_WIDTH'(STARVE_LIMIT);
  localparam logic [STARVE_WIDTH-1:0] LIMIT_M1 = STARVE_WIDTH'(STARVE_LIMIT - 1);

  typedef enum logic [1:0] {IDLE, REQ, OWN, GAP} state_e;

  state_e                  state_q, state_d;
  logic [LEN_WIDTH-1:0]    mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]     count_q, count_d;
  logic [LEN_WIDTH-1:0]    beat_rem_q, beat_rem_d;
  logic                    first_q, first_d;
  logic [STARVE_WIDTH-1:0] wait_q, wait_d;
  logic                    starved_q, starved_d;
  logic                    request_q, request_d;
  logic                    push, pop, starve_set;

  // count never exceeds DEPTH, so its MSB alone marks full
  assign cmd_ready = !count_q[DEPTH_LOG2];
  assign own       = (state_q == OWN) && grant;
  assign own_first = own && first_q;
  assign own_last  = own && (beat_rem_q == '0);
  assign push      = cmd_valid && cmd_ready;
  assign pop       = own_last;
  assign pending   = count_q;
  assign request   = request_q;
  assign starved   = starved_q;

  always_comb begin
    state_d    = state_q;
    beat_rem_d = beat_rem_q;
    first_d    = first_q;
    wait_d     = wait_q;
    starve_set = 1'b0;
    wr_ptr_d   = wr_ptr_q + DEPTH_LOG2'(push);
    rd_ptr_d   = rd_ptr_q + DEPTH_LOG2'(pop);
    count_d    = count_q + (DEPTH_LOG2+1)'(push) - (DEPTH_LOG2+1)'(pop);
    case (state_q)
      IDLE: if (count_q != '0) state_d = REQ;
      REQ: begin
        if (grant) begin
          state_d    = OWN;
          beat_rem_d = mem_q[rd_ptr_q];
          first_d    = 1'b1;
          wait_d     = '0;
        end else if (wait_q != LIMIT) begin
          wait_d     = wait_q + 1'b1;
          starve_set = (wait_q == LIMIT_M1);
        end
      end
      OWN: begin
        // grant low stalls the burst with everything held
        if (grant) begin
          first_d = 1'b0;
          if (beat_rem_q == '0) state_d = GAP;
          else                  beat_rem_d = beat_rem_q - 1'b1;
        end
      end
      GAP:     state_d = (count_q != '0) ? REQ : IDLE;
      default: state_d = IDLE;
    endcase
    request_d = (state_d == REQ) || (state_d == OWN);
    starved_d = starve_set || (starved_q && !starve_clear);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      beat_rem_q <= '0;
      first_q    <= 1'b0;
      wait_q     <= '0;
      starved_q  <= 1'b0;
      request_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      beat_rem_q <= beat_rem_d;
      first_q    <= first_d;
      wait_q     <= wait_d;
      starved_q  <= starved_d;
      request_q  <= request_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= cmd_len;
  end
endmodule

// File: tb/tb_arbiter_requester.sv
// Directed bench for arbiter_requester: beats are scored against a queue of expected
// {first,last} flags filled when commands are issued; cycle-exact checks run inline.
module tb_arbiter_requester;
  logic       clock = 1'b0, reset = 1'b1;
  logic       cmd_valid = 1'b0, starve_clear = 1'b0;
  logic [3:0] cmd_len = '0;
  logic       tie = 1'b0, gforce = 1'b0;
  logic       grant, cmd_ready, request, own, own_first, own_last, starved;
  logic [2:0] pending;
  logic [1:0] exp_q [$];
  logic [1:0] e;
  int         n_chk = 0, n_fail = 0;

  arbiter_requester dut (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_len(cmd_len),
    .cmd_ready(cmd_ready), .request(request), .grant(grant), .own(own),
    .own_first(own_first), .own_last(own_last), .pending(pending),
    .starved(starved), .starve_clear(starve_clear)
  );

  always #5 clock = ~clock;
  assign grant = tie ? request : gforce;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clock); #1;
  endtask

  task automatic push_burst(input int len);
    for (int i = 0; i <= len; i++) exp_q.push_back({1'(i == 0), 1'(i == len)});
  endtask

  // one cycle of cmd_valid; acc is the hand-computed acceptance for this cycle
  task automatic issue(input int len, input bit acc, input bit sb = 1'b1);
    cmd_valid = 1'b1;
    cmd_len   = 4'(len);
    chk("cmd_ready", int'(cmd_ready), int'(acc));
    if (acc && sb) push_burst(len);
    tick;
    cmd_valid = 1'b0;
  endtask

  always @(negedge clock) begin
    if (!reset && own) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL beat: unexpected own beat first=%0d last=%0d at %0t", own_first, own_last, $time);
      end else begin
        e = exp_q.pop_front();
        if ({own_first, own_last} !== e) begin
          n_fail++;
          $display("FAIL beat flags: got first/last=%b want %b at %0t", {own_first, own_last}, e, $time);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    // reset state
    repeat (2) @(posedge clock);
    #1;
    chk("rst request", int'(request), 0);
    chk("rst own", int'(own), 0);
    chk("rst pending", int'(pending), 0);
    chk("rst starved", int'(starved), 0);
    chk("rst cmd_ready", int'(cmd_ready), 1);
    reset = 1'b0;
    tick;

    // single 4-beat command, grant tied to request
    tie = 1'b1;
    issue(3, 1'b1);
    chk("t1 c1 pending", int'(pending), 1);
    chk("t1 c1 request", int'(request), 0);
    tick;
    chk("t1 c2 request", int'(request), 1);
    chk("t1 c2 own", int'(own), 0);
    tick;
    chk("t1 c3 own", int'(own), 1);
    chk("t1 c3 own_first", int'(own_first), 1);
    repeat (3) tick;
    chk("t1 c6 own_last", int'(own_last), 1);
    tick;
    chk("t1 c7 request", int'(request), 0);
    chk("t1 c7 pending", int'(pending), 0);
    tick;
    chk("t1 c8 request", int'(request), 0);

    // fill the queue with grant held off; no push while full, even on a pop
    tie = 1'b0; gforce = 1'b0;
    repeat (4) issue(0, 1'b1);
    chk("t2 full pending", int'(pending), 4);
    issue(1, 1'b0);
    chk("t2 held pending", int'(pending), 4);
    tie = 1'b1;
    #1;
    chk("t2 req own", int'(own), 0);
    chk("t2 req request", int'(request), 1);
    issue(1, 1'b0);
    chk("t2 pop own_last", int'(own_last), 1);
    issue(1, 1'b0);
    chk("t2 gap pending", int'(pending), 3);
    chk("t2 gap request", int'(request), 0);
    issue(1, 1'b1);
    chk("t2 refill pending", int'(pending), 4);
    k = 0;
    while (!(pending == 0 && request == 0) && k < 60) begin tick; k++; end
    chk("t2 drain in budget", int'(k < 60), 1);
    tick;

    // two 2-beat commands, grant constantly high
    tie = 1'b0; gforce = 1'b1;
    issue(1, 1'b1);
    issue(1, 1'b1);
    chk("t3 pending", int'(pending), 2);
    chk("t3 request", int'(request), 1);
    repeat (3) tick;
    chk("t3 gap request", int'(request), 0);
    chk("t3 gap pending", int'(pending), 1);
    tick;
    chk("t3 req request", int'(request), 1);
    chk("t3 req own", int'(own), 0);
    repeat (3) tick;
    chk("t3 end pending", int'(pending), 0);
    chk("t3 end request", int'(request), 0);
    repeat (2) tick;
    chk("t3 idle grant ignored request", int'(request), 0);
    chk("t3 idle grant ignored own", int'(own), 0);

    // 5-beat burst with a 3-cycle grant stall after beat 2
    issue(4, 1'b1);
    repeat (4) tick;
    gforce = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t4 stall own", int'(own), 0);
      chk("t4 stall request", int'(request), 1);
      tick;
    end
    gforce = 1'b1;
    repeat (3) tick;
    chk("t4 gap request", int'(request), 0);
    chk("t4 gap pending", int'(pending), 0);
    tick;

    // starvation: set at wait 64, sticky, cleared by a later pulse
    gforce = 1'b0;
    issue(0, 1'b1);
    tick;
    repeat (63) tick;
    chk("t5 before limit", int'(starved), 0);
    tick;
    chk("t5 at limit", int'(starved), 1);
    repeat (2) tick;
    chk("t5 sticky", int'(starved), 1);
    starve_clear = 1'b1;
    tick;
    starve_clear = 1'b0;
    chk("t5 cleared", int'(starved), 0);
    tick;
    chk("t5 stays clear", int'(starved), 0);
    tie = 1'b1;
    repeat (3) tick;
    tie = 1'b0; gforce = 1'b0;
    // clear coincident with the setting cycle: set wins
    issue(0, 1'b1);
    tick;
    repeat (63) tick;
    starve_clear = 1'b1;
    tick;
    starve_clear = 1'b0;
    chk("t5 set beats clear", int'(starved), 1);
    starve_clear = 1'b1;
    tick;
    starve_clear = 1'b0;
    chk("t5 cleared again", int'(starved), 0);
    tie = 1'b1;
    repeat (3) tick;
    chk("t5 drained", int'(pending), 0);

    // async reset during beat 2 of a 4-beat burst with 3 pending
    tie = 1'b0; gforce = 1'b0;
    issue(3, 1'b1, 1'b0);
    issue(0, 1'b1, 1'b0);
    issue(0, 1'b1, 1'b0);
    chk("t6 pending", int'(pending), 3);
    exp_q.push_back(2'b10);
    exp_q.push_back(2'b00);
    gforce = 1'b1;
    repeat (2) tick;
    @(negedge clock);
    #1;
    reset = 1'b1;
    #1;
    chk("t6 rst request", int'(request), 0);
    chk("t6 rst own", int'(own), 0);
    chk("t6 rst pending", int'(pending), 0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    chk("t6 cmd_ready", int'(cmd_ready), 1);
    tick;
    chk("t6 idle request", int'(request), 0);
    chk("t6 idle own", int'(own), 0);
    tick;
    chk("t6 idle pending", int'(pending), 0);

    chk("scoreboard empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
